// File: rtl/light_pkg.sv
// Shared definitions for the traffic-light controller and its monitor.
package light_pkg;

  typedef enum logic [1:0] {
    PH_SYNC  = 2'd0,
    PH_RED   = 2'd1,
    PH_GREEN = 2'd2,
    PH_BLUE  = 2'd3
  } phase_t;

  // Active-low RGB light codes
  localparam logic [2:0] LED_RED   = 3'b101;
  localparam logic [2:0] LED_GREEN = 3'b110;
  localparam logic [2:0] LED_BLUE  = 3'b011;

  localparam int unsigned DEF_RED_TICKS   = 540000000;
  localparam int unsigned DEF_GREEN_TICKS = 135000000;
  localparam int unsigned DEF_BLUE_TICKS  = 54000000;
  localparam int unsigned DEF_TOL         = 16;

  // Undefined codes map to PH_SYNC, which is never a light code itself
  function automatic phase_t decode_led(input logic [2:0] code);
    case (code)
      LED_RED:   return PH_RED;
      LED_GREEN: return PH_GREEN;
      LED_BLUE:  return PH_BLUE;
      default:   return PH_SYNC;
    endcase
  endfunction

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_RED:   return PH_GREEN;
      PH_GREEN: return PH_BLUE;
      PH_BLUE:  return PH_RED;
      default:  return PH_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/led_sync.sv
// Two-flop synchronizer for the 3-bit asynchronous LED code.
module led_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] d,
  output logic [2:0] q
);

  logic [2:0] s1;

  // Both stages reset to "all lights off"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '1;
      q  <= '1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/light_monitor.sv
// Watches a traffic-light LED code and checks phase order and dwell times.
module light_monitor
  import light_pkg::*;
#(
  parameter int unsigned RED_TICKS   = DEF_RED_TICKS,
  parameter int unsigned GREEN_TICKS = DEF_GREEN_TICKS,
  parameter int unsigned BLUE_TICKS  = DEF_BLUE_TICKS,
  parameter int unsigned TOL         = DEF_TOL
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [2:0]  led_in,
  input  logic        clr_err,
  output logic [1:0]  phase,
  output logic        seq_err,
  output logic        time_err,
  output logic        inv_err,
  output logic [2:0]  err_flags,
  output logic [15:0] cycle_cnt
);

  localparam logic [31:0] RED_LO   = RED_TICKS - TOL;
  localparam logic [31:0] RED_HI   = RED_TICKS + TOL;
  localparam logic [31:0] GREEN_LO = GREEN_TICKS - TOL;
  localparam logic [31:0] GREEN_HI = GREEN_TICKS + TOL;
  localparam logic [31:0] BLUE_LO  = BLUE_TICKS - TOL;
  localparam logic [31:0] BLUE_HI  = BLUE_TICKS + TOL;

  logic [2:0]  s2;
  phase_t      dec_q;
  phase_t      state, state_nxt;
  logic [31:0] dwell, dwell_nxt;
  logic        checked, checked_nxt;
  logic        run_ok, run_ok_nxt;
  logic        seq_nxt, time_nxt, inv_nxt;
  logic [2:0]  flags_nxt;
  logic [15:0] cnt_nxt;
  logic [31:0] lo, hi;

  led_sync u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (led_in),
    .q     (s2)
  );

  assign phase = state;

  // Registered decode stage, then FSM state, dwell and all outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dec_q     <= PH_SYNC;
      state     <= PH_SYNC;
      dwell     <= '0;
      checked   <= 1'b0;
      run_ok    <= 1'b0;
      seq_err   <= 1'b0;
      time_err  <= 1'b0;
      inv_err   <= 1'b0;
      err_flags <= '0;
      cycle_cnt <= '0;
    end else begin
      dec_q     <= decode_led(s2);
      state     <= state_nxt;
      dwell     <= dwell_nxt;
      checked   <= checked_nxt;
      run_ok    <= run_ok_nxt;
      seq_err   <= seq_nxt;
      time_err  <= time_nxt;
      inv_err   <= inv_nxt;
      err_flags <= flags_nxt;
      cycle_cnt <= cnt_nxt;
    end
  end

  // Next phase, dwell tracking, error detection and clean-cycle counting
  always_comb begin
    state_nxt   = state;
    dwell_nxt   = dwell;
    checked_nxt = checked;
    run_ok_nxt  = run_ok;
    seq_nxt     = 1'b0;
    time_nxt    = 1'b0;
    inv_nxt     = 1'b0;
    cnt_nxt     = cycle_cnt;
    lo          = '0;
    hi          = '0;

    case (state)
      PH_RED:   begin lo = RED_LO;   hi = RED_HI;   end
      PH_GREEN: begin lo = GREEN_LO; hi = GREEN_HI; end
      PH_BLUE:  begin lo = BLUE_LO;  hi = BLUE_HI;  end
      default:  begin lo = '0;       hi = '0;       end
    endcase

    if (dec_q == PH_SYNC) begin
      inv_nxt    = (state != PH_SYNC);
      state_nxt  = PH_SYNC;
      run_ok_nxt = 1'b0;
    end else if (state == PH_SYNC) begin
      state_nxt   = dec_q;
      dwell_nxt   = 32'd1;
      checked_nxt = 1'b0;
      run_ok_nxt  = 1'b0;
    end else if (dec_q == state) begin
      if (dwell != '1)
        dwell_nxt = dwell + 32'd1;
      if (checked && dwell == hi) begin
        time_nxt   = 1'b1;
        run_ok_nxt = 1'b0;
      end
    end else begin
      seq_nxt  = (dec_q != next_phase(state));
      // Dwell grows by one per cycle, so any dwell above hi already got the
      // stuck-light pulse on its way through hi+1; only the low bound remains.
      time_nxt = checked && (dwell < lo);
      if (state == PH_BLUE && dec_q == PH_RED && run_ok && !time_nxt)
        cnt_nxt = cycle_cnt + 16'd1;
      if (dec_q == PH_RED)
        run_ok_nxt = (state == PH_BLUE);
      else
        run_ok_nxt = run_ok && !seq_nxt && !time_nxt;
      state_nxt   = dec_q;
      dwell_nxt   = 32'd1;
      checked_nxt = 1'b1;
    end

    flags_nxt = (clr_err ? 3'b000 : err_flags) | {inv_nxt, time_nxt, seq_nxt};
  end

endmodule

// File: doc/light_monitor.md
LIGHT_MONITOR -- requirements
Module: light_monitor

Interface
REQ-001 Parameter RED_TICKS, default 540000000: nominal red dwell in sys_clk cycles.
REQ-002 Parameter GREEN_TICKS, default 135000000: nominal green dwell in cycles.
REQ-003 Parameter BLUE_TICKS, default 54000000: nominal blue dwell in cycles.
REQ-004 Parameter TOL, default 16: allowed dwell deviation in cycles, applied symmetrically.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 Port sys_clk, input, 1: single clock.
REQ-007 Port sys_rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port led_in, input, 3: observed active-low RGB light code.
REQ-009 Port clr_err, input, 1: clears all sticky error flags.
REQ-010 Port phase, output, 2: tracked phase (0 SYNC, 1 RED, 2 GREEN, 3 BLUE).
REQ-011 Port seq_err, output, 1: one-cycle pulse on an illegal phase order.
REQ-012 Port time_err, output, 1: one-cycle pulse on a dwell-time violation.
REQ-013 Port inv_err, output, 1: one-cycle pulse on an undefined light code.
REQ-014 Port err_flags, output, 3: sticky flags {inv, time, seq}.
REQ-015 Port cycle_cnt, output, 16: count of completed clean RED->GREEN->BLUE->RED cycles.

Function
REQ-016 led_in SHALL pass through a 2-flop synchronizer; only the second stage (s2) is decoded.
REQ-017 Decode SHALL be: 3'b101 RED, 3'b110 GREEN, 3'b011 BLUE; any other code is INVALID.
REQ-018 The FSM SHALL have states SYNC, RED, GREEN and BLUE; phase SHALL output the current state.
REQ-019 From SYNC, a valid s2 decode SHALL move the FSM to that phase with no sequence or time check, because the first dwell is partial.
REQ-020 The legal transitions SHALL be RED->GREEN, GREEN->BLUE and BLUE->RED; any other valid change SHALL pulse seq_err and the FSM SHALL still adopt the new phase.
REQ-021 An INVALID decode in any state SHALL pulse inv_err once and force SYNC; the FSM SHALL stay in SYNC while the decode remains INVALID, with no repeated pulse.
REQ-022 The dwell counter (32-bit) SHALL load 1 on phase entry, increment each cycle the decode equals the state, and saturate at 2^32-1.
REQ-023 On a legal exit from a checked dwell, time_err SHALL pulse if the dwell is < NOM-TOL or > NOM+TOL.
REQ-024 While in a phase, when the dwell reaches NOM+TOL+1, time_err SHALL pulse once (stuck light); that dwell SHALL NOT be flagged again on exit.
REQ-025 A dwell entered from SYNC SHALL NOT be time-checked; every later dwell SHALL be checked.
REQ-026 cycle_cnt SHALL increment on each BLUE->RED transition that completes a RED, GREEN, BLUE run with no error pulse since the last RED entry, and SHALL wrap at 16 bits.
REQ-027 Latency: a led_in change before edge k SHALL be reflected in phase and the error pulses after edge k+3; all outputs SHALL be registered.
REQ-028 If a sticky flag's error pulse coincides with clr_err, the flag SHALL be set; in the same cycle, clr_err SHALL clear the other flags.
REQ-029 seq_err and time_err MAY pulse in the same cycle, for example on an illegal change that ends an out-of-tolerance dwell.

Reset
REQ-030 Reset SHALL set the FSM to SYNC, phase=0, all pulses=0, err_flags=0, cycle_cnt=0, dwell=0, and both sync flops to 3'b111.
REQ-031 Reset asserted mid-dwell SHALL discard that dwell; after release, the first phase SHALL be unchecked per REQ-019.

Structure
REQ-032 Package light_pkg SHALL hold the phase enum, the three active-low LED code constants and the default tick constants, shared with the light controller.
REQ-033 Sub-module led_sync SHALL implement the 3-bit 2-flop synchronizer; everything else SHALL be in light_monitor.

Verification
REQ-034 Bench parameters: RED_TICKS=20, GREEN_TICKS=8, BLUE_TICKS=4, TOL=1.
REQ-035 Reset release, then RED 20 / GREEN 8 / BLUE 4 / RED 20 / GREEN 8 / BLUE 4 / RED -> no errors, cycle_cnt=1 (first cycle unchecked).
REQ-036 In a checked cycle, GREEN held 6 cycles -> time_err pulse at GREEN exit + 3 cycles, err_flags=3'b010, cycle_cnt unchanged.
REQ-037 RED then BLUE directly -> seq_err pulse, phase=3, err_flags[0]=1.
REQ-038 Code 3'b000 for 1 cycle mid-GREEN -> single inv_err pulse, phase=0, then GREEN unchecked.
REQ-039 RED held 30 cycles -> time_err at dwell 22, no second pulse at exit; clr_err coincident with a new seq_err -> err_flags[0] remains 1.
REQ-040 sys_rst_n pulsed low mid-BLUE -> all outputs 0 immediately, and the next BLUE->RED raises no errors.
